// File: rtl/vga_mem_write_arbiter.sv
// vga_mem_write_arbiter
//   Single write port into the VGA tile/frame memory. Two requesters share it: the
//   processor (p_*) and the game-logic engine (g_*). Ties are broken round-robin.
//   Writes can be limited to vertical blanking. A built-in sequencer can sweep the
//   whole memory with CLEAR_VALUE.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   p_req/p_addr/p_data, p_ack   processor request; p_ack is a combinational grant
//   g_req/g_addr/g_data, g_ack   game-engine request; g_ack is a combinational grant
//   vblank                       write window (ignored when GATE_VBLANK == 0)
//   clear_start                  one-cycle pulse that starts a full-memory clear
//   clear_busy, clear_done       clear status; done pulses with the last clear write
//   mem_we/mem_addr/mem_wdata    registered write port toward the VGA memory
module vga_mem_write_arbiter #(
  parameter int unsigned        ADDR_W      = 12,
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        DEPTH       = 4096,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0,
  parameter bit                 GATE_VBLANK = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_ack,
  input  logic              g_req,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_data,
  output logic              g_ack,
  input  logic              vblank,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // One extra counter bit so the sweep cannot wrap before it terminates.
  localparam logic [ADDR_W:0] LastCnt = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CntOne  = (ADDR_W + 1)'(1);

  state_e              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic                last_grant_q;  // 1: game engine was granted last
  logic                busy_q;
  logic                done_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic                open;
  logic                grant_ok;

  always_comb begin
    open     = !GATE_VBLANK || vblank;
    // A clear_start in the same cycle beats any request; requests stay pending.
    grant_ok = (state_q == StIdle) && open && !clear_start;
    // Under contention, grant whoever was not granted last.
    p_ack    = grant_ok && p_req && (!g_req || last_grant_q);
    g_ack    = grant_ok && g_req && (!p_req || !last_grant_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (clear_start) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (p_ack) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= p_addr;
            mem_wdata_q  <= p_data;
            last_grant_q <= 1'b0;
          end else if (g_ack) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= g_addr;
            mem_wdata_q  <= g_data;
            last_grant_q <= 1'b1;
          end
        end
        StClear: begin
          // Closed cycles stall the sweep; busy stays high through the done cycle.
          if (open) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= cnt_q[ADDR_W-1:0];
            mem_wdata_q <= CLEAR_VALUE;
            if (cnt_q == LastCnt) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vga_mem_write_arbiter.sv
// Directed bench for vga_mem_write_arbiter (DEPTH = 16, vblank gating on).
// Inputs change 1 ns after a rising edge; everything is sampled on the falling edge.
module tb_vga_mem_write_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned DP = 16;
  localparam logic [DW-1:0] CV = 32'hA5A5_0000;

  logic          clock;
  logic          reset;
  logic          p_req, g_req, p_ack, g_ack;
  logic [AW-1:0] p_addr, g_addr, mem_addr;
  logic [DW-1:0] p_data, g_data, mem_wdata;
  logic          vblank, clear_start, clear_busy, clear_done, mem_we;

  int n_chk = 0;
  int n_bad = 0;

  vga_mem_write_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .DEPTH      (DP),
    .CLEAR_VALUE(CV),
    .GATE_VBLANK(1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .p_req      (p_req),
    .p_addr     (p_addr),
    .p_data     (p_data),
    .p_ack      (p_ack),
    .g_req      (g_req),
    .g_addr     (g_addr),
    .g_data     (g_data),
    .g_ack      (g_ack),
    .vblank     (vblank),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    p_req       = 1'b0;
    g_req       = 1'b0;
    clear_start = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic acked;
  logic prev_v;
  int   nwr;

  initial begin
    reset = 1'b1; p_req = 0; g_req = 0; p_addr = '0; g_addr = '0; p_data = '0;
    g_data = '0; vblank = 1'b0; clear_start = 1'b0;
    step(); step();
    // Reset state
    mid();
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    step();
    reset = 1'b0;

    // 1: single processor write
    vblank = 1'b1; p_req = 1'b1; p_addr = 12'h010; p_data = 32'hDEADBEEF;
    mid();
    chk("t1_pack", p_ack, 1);
    chk("t1_gack", g_ack, 0);
    step();
    p_req = 1'b0;
    mid();
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, 12'h010);
    chk("t1_data", mem_wdata, 32'hDEADBEEF);
    step();
    mid();
    chk("t1_we_off", mem_we, 0);
    chk("t1_addr_hold", mem_addr, 12'h010);
    step();

    // 2: contention from reset -> P, G, P, G
    do_reset();
    p_req = 1; p_addr = 12'h100; p_data = 32'h1111_1111;
    g_req = 1; g_addr = 12'h200; g_data = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("t2_pack", p_ack, (i % 2) == 0);
      chk("t2_gack", g_ack, (i % 2) == 1);
      if (i > 0) begin
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, ((i % 2) == 1) ? 12'h100 : 12'h200);
      end
      step();
    end
    p_req = 0; g_req = 0;
    mid();
    chk("t2_last_addr", mem_addr, 12'h200);
    chk("t2_last_data", mem_wdata, 32'h2222_2222);
    step();

    // 3: blocked outside vblank, granted once it opens
    vblank = 0; p_req = 1; p_addr = 12'h0AB; p_data = 32'hCAFE_0001;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("t3_closed_ack", p_ack, 0);
      chk("t3_closed_we", mem_we, 0);
      step();
    end
    vblank = 1;
    mid();
    chk("t3_open_ack", p_ack, 1);
    step();
    p_req = 0;
    mid();
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 12'h0AB);
    step();

    // 4: full clear, request arriving with clear_start waits until the clear ends
    clear_start = 1; p_req = 1; p_addr = 12'h333; p_data = 32'h0000_0033;
    mid();
    chk("t4_clr_wins", p_ack, 0);
    step();
    clear_start = 0;
    mid();
    chk("t4_busy0", clear_busy, 1);
    chk("t4_we0", mem_we, 0);
    chk("t4_ack0", p_ack, 0);
    step();
    acked = 1'b0;
    for (int k = 0; k < 16; k++) begin
      mid();
      chk("t4_we", mem_we, 1);
      chk("t4_addr", mem_addr, k);
      chk("t4_data", mem_wdata, CV);
      chk("t4_done", clear_done, k == 15);
      chk("t4_busy", clear_busy, 1);
      if (k < 15) chk("t4_ack_blocked", p_ack, 0);
      else acked = p_ack;
      step();
    end
    if (!acked) begin
      for (int w = 0; w < 4 && !acked; w++) begin
        mid();
        if (p_ack) acked = 1'b1;
        step();
      end
    end
    p_req = 0;
    chk("t4_ack_after", acked, 1);
    mid();
    chk("t4_p_we", mem_we, 1);
    chk("t4_p_addr", mem_addr, 12'h333);
    chk("t4_busy_off", clear_busy, 0);
    chk("t4_done_off", clear_done, 0);
    step();

    // 5: clear with vblank 3 on / 2 off
    vblank = 1; clear_start = 1;
    step();
    clear_start = 0;
    prev_v = 1'b0;
    nwr = 0;
    for (int c = 0; c < 60 && nwr < 16; c++) begin
      vblank = (c % 5) < 3;
      mid();
      chk("t5_we", mem_we, prev_v);
      if (mem_we) begin
        chk("t5_addr", mem_addr, nwr);
        chk("t5_data", mem_wdata, CV);
        chk("t5_done", clear_done, nwr == 15);
        nwr++;
      end else begin
        chk("t5_no_done", clear_done, 0);
      end
      prev_v = vblank;
      step();
    end
    chk("t5_total", nwr, 16);
    vblank = 1;
    mid();
    chk("t5_busy_off", clear_busy, 0);
    chk("t5_we_off", mem_we, 0);
    step();

    // 6: reset in the middle of a clear
    clear_start = 1;
    step();
    clear_start = 0;
    mid();
    chk("t6_no_we", mem_we, 0);
    step();
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("t6_addr", mem_addr, k);
      if (k < 5) step();
    end
    reset = 1;
    step();
    mid();
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_busy", clear_busy, 0);
    chk("t6_rst_done", clear_done, 0);
    reset = 0;
    step();
    mid();
    chk("t6_still_no_done", clear_done, 0);
    chk("t6_still_no_we", mem_we, 0);
    step();
    clear_start = 1;
    step();
    clear_start = 0;
    mid();
    chk("t6_restart_busy", clear_busy, 1);
    chk("t6_restart_we0", mem_we, 0);
    step();
    mid();
    chk("t6_restart_we", mem_we, 1);
    chk("t6_restart_addr", mem_addr, 0);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
